fpu_decode_stage: RTL
=====================

// Module: fpu_decode_stage
// PURPOSE
//  Front-end issue stage of the Zhinx half-precision FPU: accepts one 32-bit RISC-V FP instruction with its integer-regfile operands,
//  decodes it into an fpu_operation_t plus sub-op and resolved rounding mode, and registers the result toward the FPU datapath.
//  Valid/ready handshake on both sides; flags illegal encodings in-band instead of dropping them.
// PARAMETERS
//  WORD_W   32  instruction / integer operand width (fpu_types_pkg)
//  HALF_W   16  FP operand width taken from operand LSBs (HALF_FLOAT_W)
// PORTS
//  CLK          in   1   clock
//  RST          in   1   synchronous, active-high reset
//  flush        in   1   sync squash of all held entries
//  in_valid     in   1   upstream has instruction
//  in_ready     out  1   stage can accept
//  in_instr     in   32  instruction word
//  in_rs1/2/3   in   32  integer regfile reads (Zhinx; bits [15:0] used)
//  frm          in   3   dynamic rounding mode from fcsr
//  out_valid    out  1   decoded entry available
//  out_ready    in   1   datapath accepts
//  out_op       out  enum fpu_operation_t (sized via pkg typedef)
//  out_subop    out  2   MIN/MAX, SGNJ/N/X, FLE/FLT/FEQ select
//  out_rm       out  3   resolved rounding mode (never RM_DYN)
//  out_a/b/c    out  16  operands rs1/rs2/rs3 [15:0]
//  out_rd       out  5   destination register
//  out_illegal  out  1   illegal instruction; other fields zero
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* data=0, in_ready=1. Flush same effect as reset on valid bits only.
//  - Transfer on valid&&ready each side; latency 1 cycle in->out; 1 instr/cycle sustained with out_ready=1.
//  - out_* stable while out_valid && !out_ready; in_valid may not be revoked by upstream (not checked).
//  - Decode: opcode in {OPFP,FMADD,FMSUB,FNMADD,FNMSUB} else illegal; fmt=instr[26:25] must be FMT_HALF else illegal.
//  - R4 opcodes -> MADD/MSUB/NMADD/NMSUB, rs3 = instr[31:27]. OPFP -> funct5=instr[31:27] per fpu_funct_t; unknown funct5 illegal.
//  - rm=instr[14:12]; RM_DYN -> frm. Resolved rm in {101,110,111} illegal for ADD/SUB/MUL/DIV/SQRT/R4 ops.
//  - MINMAX: rm 000 MIN, 001 MAX, else illegal. SGNJ: rm 000/001/010 -> subop 0/1/2, 011+ illegal.
//  - COMP: rm 000 FLE, 001 FLT, 010 FEQ -> subop 0/1/2, else illegal. Static rm for these not substituted by frm.
//  - SQRT requires rs2 field 0; CLASS requires rs2 field 0 and rm 001; violation illegal.
//  - Illegal entry: out_illegal=1, out_op=FPU_HALF_ADD, subop/rm/operands=0, out_rd still driven; consumes one handshake.
//  - Simultaneous flush and in_valid&&in_ready: flush wins, input discarded, in_ready remains as reset value next cycle.
//  - Reset mid-stall: held entry discarded, no output handshake.
// CONFIGURATION
//  FPU_DECODE_SKID_EN defined: 2-entry skid buffer; in_ready is a registered flop (=skid slot empty), no comb path out_ready->in_ready;
//   full throughput kept; on out_ready low, at most one extra entry captured into skid, drained first-in-first-out.
//  Undefined: single output register, in_ready = !out_valid || out_ready (combinational).
//  Both variants: identical out_* sequences for identical handshake traces.
// STRUCTURE
//  fpu_types_pkg additions: sized fpu_op_t (logic [3:0] enum mirror of fpu_operation_t), fpu_subop_t,
//   fpu_decoded_t packed struct {op,subop,rm,a,b,c,rd,illegal}, RM_RSVD_MIN=3'b101.
//  Sub-module fpu_decode_logic: pure combinational instr+frm+operands -> fpu_decoded_t; this module owns registers/handshake.
// TESTING
//  fadd.h x3,x1,x2 0x042081D3, rs1=0x3C00, rs2=0x4000, frm=000 -> next cycle op=ADD rm=000 a=3C00 b=4000 rd=3 illegal=0.
//  Same instr with rm=111 (0x0420F1D3), frm=011 -> rm=011; frm=101 -> illegal=1, operands 0.
//  fmt=single 0x002081D3 -> illegal=1; fmin.h rm=000 -> MIN subop 0; rm=010 -> illegal; feq.h rm=010 -> COMP subop 2.
//  Back-to-back 8 instrs, out_ready held 0 for 3 cycles mid-stream -> in order, none lost/duplicated (skid on and off).
//  flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, neither entry ever appears.
//  RST pulsed while stalled with valid entry -> out_valid=0, in_ready=1 next cycle, outputs zero.

Source files
------------

// File: rtl/fpu_types_pkg.sv
// Shared types for the Zhinx half-precision FPU front end: opcodes, funct5
// codes, rounding modes, operation/sub-op encodings and the decoded entry
// that the decode stage hands to the datapath.
package fpu_types_pkg;

    localparam int WORD_W       = 32;
    localparam int HALF_FLOAT_W = 16;

    // Major opcodes that carry FP instructions.
    typedef enum logic [6:0] {
        OPC_FMADD  = 7'b1000011,
        OPC_FMSUB  = 7'b1000111,
        OPC_FNMSUB = 7'b1001011,
        OPC_FNMADD = 7'b1001111,
        OPC_OPFP   = 7'b1010011
    } fpu_opcode_t;

    // funct5 (instr[31:27]) values understood under OP-FP.
    typedef enum logic [4:0] {
        FUNCT_ADD    = 5'b00000,
        FUNCT_SUB    = 5'b00001,
        FUNCT_MUL    = 5'b00010,
        FUNCT_DIV    = 5'b00011,
        FUNCT_SGNJ   = 5'b00100,
        FUNCT_MINMAX = 5'b00101,
        FUNCT_SQRT   = 5'b01011,
        FUNCT_CMP    = 5'b10100,
        FUNCT_CLASS  = 5'b11100
    } fpu_funct_t;

    localparam logic [1:0] FMT_HALF = 2'b10;

    // Rounding modes; 101 and above are reserved except 111 (dynamic).
    localparam logic [2:0] RM_RNE      = 3'b000;
    localparam logic [2:0] RM_RTZ      = 3'b001;
    localparam logic [2:0] RM_RDN      = 3'b010;
    localparam logic [2:0] RM_RSVD_MIN = 3'b101;
    localparam logic [2:0] RM_DYN      = 3'b111;

    // Datapath operation.
    typedef enum logic [3:0] {
        FPU_HALF_ADD    = 4'd0,
        FPU_HALF_SUB    = 4'd1,
        FPU_HALF_MUL    = 4'd2,
        FPU_HALF_DIV    = 4'd3,
        FPU_HALF_SQRT   = 4'd4,
        FPU_HALF_MADD   = 4'd5,
        FPU_HALF_MSUB   = 4'd6,
        FPU_HALF_NMSUB  = 4'd7,
        FPU_HALF_NMADD  = 4'd8,
        FPU_HALF_MINMAX = 4'd9,
        FPU_HALF_SGNJ   = 4'd10,
        FPU_HALF_COMP   = 4'd11,
        FPU_HALF_CLASS  = 4'd12
    } fpu_op_t;

    typedef fpu_op_t fpu_operation_t;

    // Sub-operation select; meaning depends on the operation.
    typedef logic [1:0] fpu_subop_t;
    localparam fpu_subop_t SUBOP_NONE  = 2'd0;
    localparam fpu_subop_t SUBOP_MIN   = 2'd0;
    localparam fpu_subop_t SUBOP_MAX   = 2'd1;
    localparam fpu_subop_t SUBOP_SGNJ  = 2'd0;
    localparam fpu_subop_t SUBOP_SGNJN = 2'd1;
    localparam fpu_subop_t SUBOP_SGNJX = 2'd2;
    localparam fpu_subop_t SUBOP_FLE   = 2'd0;
    localparam fpu_subop_t SUBOP_FLT   = 2'd1;
    localparam fpu_subop_t SUBOP_FEQ   = 2'd2;

    // One decoded instruction as presented to the datapath.
    typedef struct packed {
        fpu_op_t                 op;
        fpu_subop_t              subop;
        logic [2:0]              rm;
        logic [HALF_FLOAT_W-1:0] a;
        logic [HALF_FLOAT_W-1:0] b;
        logic [HALF_FLOAT_W-1:0] c;
        logic [4:0]              rd;
        logic                    illegal;
    } fpu_decoded_t;

    localparam int DECODED_W = $bits(fpu_decoded_t);

    // True for the reserved rounding-mode encodings 101/110/111.
    function automatic logic rm_is_reserved(input logic [2:0] rm);
        return (rm >= RM_RSVD_MIN);
    endfunction

endpackage

// File: rtl/fpu_decode_stage_logic.sv
// Purely combinational decoder: instruction word, dynamic rounding mode and
// integer-register operands in, one packed fpu_decoded_t out. Any encoding
// outside the half-precision subset collapses to an illegal entry that keeps
// only the destination register.
module fpu_decode_logic
    import fpu_types_pkg::*;
(
    input  logic [WORD_W-1:0]       instr,
    input  logic [2:0]              frm,
    input  logic [HALF_FLOAT_W-1:0] rs1,
    input  logic [HALF_FLOAT_W-1:0] rs2,
    input  logic [HALF_FLOAT_W-1:0] rs3,
    output logic [DECODED_W-1:0]    decoded
);

    logic [6:0]   opcode_s;
    logic [4:0]   funct5_s;
    logic [1:0]   fmt_s;
    logic [4:0]   rs2_field_s;
    logic [2:0]   rm_field_s;
    logic [2:0]   rm_dyn_s;
    logic [2:0]   rm_s;
    fpu_op_t      op_s;
    fpu_subop_t   subop_s;
    logic         enc_ok_s;
    logic         rounded_s;
    logic         legal_s;
    fpu_decoded_t result_s;
    logic         rs1_field_unused_s;

    assign opcode_s           = instr[6:0];
    assign funct5_s           = instr[31:27];
    assign fmt_s              = instr[26:25];
    assign rs2_field_s        = instr[24:20];
    assign rm_field_s         = instr[14:12];
    assign rs1_field_unused_s = ^instr[19:15];

    // Dynamic rounding only applies to ops that round; others read rm as a selector.
    assign rm_dyn_s = (rm_field_s == RM_DYN) ? frm : rm_field_s;
    assign rm_s     = rounded_s ? rm_dyn_s : rm_field_s;

    // Classify opcode/funct5 into an operation and check its field constraints.
    always_comb begin
        op_s      = FPU_HALF_ADD;
        subop_s   = SUBOP_NONE;
        enc_ok_s  = 1'b0;
        rounded_s = 1'b0;
        case (opcode_s)
            OPC_FMADD:  begin op_s = FPU_HALF_MADD;  enc_ok_s = 1'b1; rounded_s = 1'b1; end
            OPC_FMSUB:  begin op_s = FPU_HALF_MSUB;  enc_ok_s = 1'b1; rounded_s = 1'b1; end
            OPC_FNMSUB: begin op_s = FPU_HALF_NMSUB; enc_ok_s = 1'b1; rounded_s = 1'b1; end
            OPC_FNMADD: begin op_s = FPU_HALF_NMADD; enc_ok_s = 1'b1; rounded_s = 1'b1; end
            OPC_OPFP: begin
                case (funct5_s)
                    FUNCT_ADD: begin op_s = FPU_HALF_ADD; enc_ok_s = 1'b1; rounded_s = 1'b1; end
                    FUNCT_SUB: begin op_s = FPU_HALF_SUB; enc_ok_s = 1'b1; rounded_s = 1'b1; end
                    FUNCT_MUL: begin op_s = FPU_HALF_MUL; enc_ok_s = 1'b1; rounded_s = 1'b1; end
                    FUNCT_DIV: begin op_s = FPU_HALF_DIV; enc_ok_s = 1'b1; rounded_s = 1'b1; end
                    FUNCT_SQRT: begin
                        op_s      = FPU_HALF_SQRT;
                        rounded_s = 1'b1;
                        enc_ok_s  = (rs2_field_s == 5'd0);
                    end
                    FUNCT_SGNJ: begin
                        op_s     = FPU_HALF_SGNJ;
                        subop_s  = rm_field_s[1:0];
                        enc_ok_s = (rm_field_s <= RM_RDN);
                    end
                    FUNCT_MINMAX: begin
                        op_s     = FPU_HALF_MINMAX;
                        subop_s  = rm_field_s[1:0];
                        enc_ok_s = (rm_field_s <= RM_RTZ);
                    end
                    FUNCT_CMP: begin
                        op_s     = FPU_HALF_COMP;
                        subop_s  = rm_field_s[1:0];
                        enc_ok_s = (rm_field_s <= RM_RDN);
                    end
                    FUNCT_CLASS: begin
                        op_s     = FPU_HALF_CLASS;
                        enc_ok_s = (rs2_field_s == 5'd0) && (rm_field_s == RM_RTZ);
                    end
                    default: begin
                        enc_ok_s = 1'b0;
                    end
                endcase
            end
            default: begin
                enc_ok_s = 1'b0;
            end
        endcase
    end

    assign legal_s = enc_ok_s && (fmt_s == FMT_HALF) &&
                     !(rounded_s && rm_is_reserved(rm_s));

    // Assemble the entry; illegal entries keep rd and zero everything else.
    always_comb begin
        result_s    = '0;
        result_s.rd = instr[11:7];
        if (legal_s) begin
            result_s.op      = op_s;
            result_s.subop   = subop_s;
            result_s.rm      = rm_s;
            result_s.a       = rs1;
            result_s.b       = rs2;
            result_s.c       = rs3;
            result_s.illegal = 1'b0;
        end else begin
            result_s.illegal = 1'b1;
        end
    end

    assign decoded = result_s;

endmodule

// File: rtl/fpu_decode_stage.sv
// Issue stage of the Zhinx half-precision FPU. Decodes one instruction per
// cycle and registers it toward the datapath with valid/ready on both sides.
// Build option FPU_DECODE_SKID_EN: adds a second entry so in_ready becomes a
// flop with no combinational path from out_ready. Without it a single output
// register is used and in_ready = !out_valid || out_ready.
module fpu_decode_stage
    import fpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int HALF_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_instr,
    input  logic [WORD_W-1:0] in_rs1,
    input  logic [WORD_W-1:0] in_rs2,
    input  logic [WORD_W-1:0] in_rs3,
    input  logic [2:0]        frm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [1:0]        out_subop,
    output logic [2:0]        out_rm,
    output logic [HALF_W-1:0] out_a,
    output logic [HALF_W-1:0] out_b,
    output logic [HALF_W-1:0] out_c,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    logic [DECODED_W-1:0] dec_bits_s;
    fpu_decoded_t         dec_s;
    fpu_decoded_t         out_data_r;
    logic                 out_valid_r;
    logic                 in_ready_s;
    logic                 in_fire_s;
    logic                 rs_hi_unused_s;

    assign rs_hi_unused_s = ^{in_rs1[WORD_W-1:HALF_W], in_rs2[WORD_W-1:HALF_W],
                              in_rs3[WORD_W-1:HALF_W]};

    fpu_decode_logic u_decode (
        .instr   (in_instr),
        .frm     (frm),
        .rs1     (in_rs1[HALF_W-1:0]),
        .rs2     (in_rs2[HALF_W-1:0]),
        .rs3     (in_rs3[HALF_W-1:0]),
        .decoded (dec_bits_s)
    );

    assign dec_s     = dec_bits_s;
    assign in_fire_s = in_valid && in_ready_s;

`ifdef FPU_DECODE_SKID_EN
    fpu_decoded_t skid_data_r;
    logic         skid_valid_r;
    logic         in_ready_r;
    fpu_decoded_t out_data_n_s;
    fpu_decoded_t skid_data_n_s;
    logic         out_valid_n_s;
    logic         skid_valid_n_s;

    // Next state: refill output from skid first, else from input; park input in skid on stall.
    always_comb begin
        out_valid_n_s  = out_valid_r;
        out_data_n_s   = out_data_r;
        skid_valid_n_s = skid_valid_r;
        skid_data_n_s  = skid_data_r;
        if (!out_valid_r || out_ready) begin
            if (skid_valid_r) begin
                out_valid_n_s  = 1'b1;
                out_data_n_s   = skid_data_r;
                skid_valid_n_s = 1'b0;
            end else if (in_fire_s) begin
                out_valid_n_s = 1'b1;
                out_data_n_s  = dec_s;
            end else begin
                out_valid_n_s = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_valid_n_s = 1'b1;
                skid_data_n_s  = dec_s;
            end else begin
                skid_valid_n_s = skid_valid_r;
            end
        end
    end

    // State registers; flush drops both entries but keeps their stale data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            in_ready_r   <= 1'b1;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            out_valid_r  <= out_valid_n_s;
            out_data_r   <= out_data_n_s;
            skid_valid_r <= skid_valid_n_s;
            skid_data_r  <= skid_data_n_s;
            in_ready_r   <= !skid_valid_n_s;
        end
    end

    assign in_ready_s = in_ready_r;
`else
    // Single output register: load on accept, drop valid once drained.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (in_fire_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= dec_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready_s = !out_valid_r || out_ready;
`endif

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_op      = out_data_r.op;
    assign out_subop   = out_data_r.subop;
    assign out_rm      = out_data_r.rm;
    assign out_a       = out_data_r.a;
    assign out_b       = out_data_r.b;
    assign out_c       = out_data_r.c;
    assign out_rd      = out_data_r.rd;
    assign out_illegal = out_data_r.illegal;

endmodule
